// File: rtl/imm_splitter.sv
// Streaming splitter that turns a 16-bit constant into the shortest chain of 7-bit
// immediates rebuilt by sext(chunk0) followed by repeated (acc << 7) | chunk.
module imm_splitter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         out_imm,
    output logic               out_first,
    output logic               out_last,
    output logic [1:0]         out_idx,
    output logic [1:0]         out_nchunks,
    output logic [COUNT_W-1:0] words_done
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state, state_nxt;
    logic signed [15:0] v_p0;
    logic [1:0]         n_p0;
    logic [1:0]         idx_p0;
    logic               last_p0;
    logic               out_fire;
    logic               in_fire;

    function automatic logic [1:0] chunk_count(input logic signed [15:0] v);
        if ((&v[15:6]) || !(|v[15:6]))
            return 2'd1;
        else if ((&v[15:13]) || !(|v[15:13]))
            return 2'd2;
        else
            return 2'd3;
    endfunction

    // Short words skip the leading positions, so chunk k of an n-chunk word
    // sits at position k + (3 - n) of the full 3-chunk layout.
    function automatic logic [6:0] chunk_sel(input logic signed [15:0] v,
                                             input logic [1:0] n,
                                             input logic [1:0] idx);
        logic [1:0] pos;
        pos = idx + (2'd3 - n);
        case (pos)
            2'd0:    return {{5{v[15]}}, v[15:14]};
            2'd1:    return v[13:7];
            default: return v[6:0];
        endcase
    endfunction

    assign last_p0  = (idx_p0 == (n_p0 - 2'd1));
    assign out_fire = (state == EMIT) & out_ready;
    assign in_ready = (state == IDLE) | (out_fire & last_p0);
    assign in_fire  = in_valid & in_ready;

    // ---- stage p0: control state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx_p0     <= 2'd0;
            words_done <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire)
                idx_p0 <= 2'd0;
            else if (out_fire && !last_p0)
                idx_p0 <= idx_p0 + 2'd1;
            if (out_fire && last_p0)
                words_done <= words_done + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            v_p0 <= in_data;
            n_p0 <= chunk_count(in_data);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EMIT;
            EMIT:    if (out_fire && last_p0) state_nxt = in_valid ? EMIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid   = 1'b0;
        out_imm     = 7'd0;
        out_first   = 1'b0;
        out_last    = 1'b0;
        out_idx     = 2'd0;
        out_nchunks = 2'd0;
        if (state == EMIT) begin
            out_valid   = 1'b1;
            out_imm     = chunk_sel(v_p0, n_p0, idx_p0);
            out_first   = (idx_p0 == 2'd0);
            out_last    = last_p0;
            out_idx     = idx_p0;
            out_nchunks = n_p0;
        end
    end

endmodule

// File: tb/tb_imm_splitter.sv
// Self-checking bench for imm_splitter: table vectors, random words against an
// arithmetic reference model, back-to-back streaming and asynchronous reset.
module tb_imm_splitter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = 16'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [6:0]    out_imm;
    logic          out_first;
    logic          out_last;
    logic [1:0]    out_idx;
    logic [1:0]    out_nchunks;
    logic [CW-1:0] words_done;

    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic [CW-1:0] exp_done = '0;

    imm_splitter #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_first(out_first), .out_last(out_last), .out_idx(out_idx),
        .out_nchunks(out_nchunks), .words_done(words_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        int          n;
        logic [6:0]  c0, c1, c2;
        bit          rnd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: chunk count from the signed value range, chunk k is the
    // arithmetic-shifted value's low 7 bits.
    function automatic int model_n(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s >= -64 && s <= 63) return 1;
        if (s >= -8192 && s <= 8191) return 2;
        return 3;
    endfunction

    function automatic logic [6:0] model_chunk(input logic [15:0] v, input int n, input int k);
        int s;
        s = int'($signed(v)) >>> (7 * (n - 1 - k));
        return 7'(s);
    endfunction

    task automatic run_word(input logic [15:0] v, input int en,
                            input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                            input bit rnd);
        logic [6:0]  ec[3];
        logic [15:0] acc;
        int          k, cyc, guard;
        ec[0] = e0; ec[1] = e1; ec[2] = e2;
        acc = 16'd0;
        @(negedge clk);
        in_data = v; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 20) check("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        k = 0; cyc = 0;
        while (k < en && cyc < 100) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = !(out_ready && k == en - 1);
            in_data   = 16'($urandom);
            #1;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_imm", 32'(out_imm), 32'(ec[k]));
            check("out_idx", 32'(out_idx), 32'(k));
            check("out_first", 32'(out_first), 32'(k == 0));
            check("out_last", 32'(out_last), 32'(k == en - 1));
            check("out_nchunks", 32'(out_nchunks), 32'(en));
            check("in_ready_emit", 32'(in_ready), 32'(out_ready && k == en - 1));
            if (out_ready) begin
                if (k == 0) acc = {{9{out_imm[6]}}, out_imm};
                else        acc = {acc[8:0], out_imm};
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) check("emit_timeout", 32'(k), 32'(en));
        in_valid = 1'b0;
        #1;
        exp_done = exp_done + 1'b1;
        check("idle_after_word", 32'(out_valid), 32'd0);
        check("reconstruct", 32'(acc), 32'(v));
        check("words_done", 32'(words_done), 32'(exp_done));
    endtask

    initial begin
        vec_t        tbl[10];
        logic [15:0] words[3];
        logic [6:0]  exp_q[$];
        logic [15:0] tmp, rv;
        int          wi, rn;
        bit          acc_now;

        tbl[0] = '{16'h0005, 1, 7'h05, 7'h00, 7'h00, 1'b0};
        tbl[1] = '{16'hFFC0, 1, 7'h40, 7'h00, 7'h00, 1'b0};
        tbl[2] = '{16'h0040, 2, 7'h00, 7'h40, 7'h00, 1'b0};
        tbl[3] = '{16'hE000, 2, 7'h40, 7'h00, 7'h00, 1'b0};
        tbl[4] = '{16'h2000, 3, 7'h00, 7'h40, 7'h00, 1'b0};
        tbl[5] = '{16'h8000, 3, 7'h7E, 7'h00, 7'h00, 1'b0};
        tbl[6] = '{16'h7FFF, 3, 7'h01, 7'h7F, 7'h7F, 1'b0};
        tbl[7] = '{16'h1234, 2, 7'h24, 7'h34, 7'h00, 1'b1};
        tbl[8] = '{16'h003F, 1, 7'h3F, 7'h00, 7'h00, 1'b1};
        tbl[9] = '{16'hDFFF, 3, 7'h7F, 7'h3F, 7'h7F, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", 32'(out_imm), 32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_nchunks", 32'(out_nchunks), 32'd0);
        check("rst_words_done", 32'(words_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++)
            run_word(tbl[i].v, tbl[i].n, tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].rnd);

        // Back-to-back stream with no bubbles
        words[0] = 16'h0001; words[1] = 16'h0100; words[2] = 16'h4000;
        for (int w = 0; w < 3; w++) begin
            rn = model_n(words[w]);
            for (int k = 0; k < rn; k++) exp_q.push_back(model_chunk(words[w], rn, k));
        end
        check("b2b_len", 32'(exp_q.size()), 32'd6);
        @(negedge clk);
        wi = 0; in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            #1;
            if (cyc > 0) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_imm", 32'(out_imm), 32'(exp_q[cyc - 1]));
            end
            acc_now = in_valid && in_ready;
            @(negedge clk);
            if (acc_now) begin
                wi++;
                if (wi < 3) in_data = words[wi];
                else        in_valid = 1'b0;
            end
        end
        #1;
        exp_done = exp_done + 3'd3;
        check("b2b_idle", 32'(out_valid), 32'd0);
        check("b2b_words_done", 32'(words_done), 32'(exp_done));

        // Random words against the model, including counter wrap
        for (int i = 0; i < 30; i++) begin
            tmp = 16'($urandom);
            rv  = 16'($signed(tmp) >>> $urandom_range(0, 12));
            rn  = model_n(rv);
            run_word(rv, rn, model_chunk(rv, rn, 0),
                     (rn > 1) ? model_chunk(rv, rn, 1) : 7'h00,
                     (rn > 2) ? model_chunk(rv, rn, 2) : 7'h00, 1'b1);
        end

        // Asynchronous reset during idx1 of 0x8000
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h8000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_idx0", 32'(out_idx), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("mid_idx1", 32'(out_idx), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_imm", 32'(out_imm), 32'd0);
        check("arst_out_idx", 32'(out_idx), 32'd0);
        check("arst_out_first", 32'(out_first), 32'd0);
        check("arst_out_last", 32'(out_last), 32'd0);
        check("arst_out_nchunks", 32'(out_nchunks), 32'd0);
        check("arst_words_done", 32'(words_done), 32'd0);
        exp_done = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_word(16'h0005, 1, 7'h05, 7'h00, 7'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
